// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: opcode of HALT, datapath
// widths, the NOP encoding and the fetch FSM state type.
package if_stage_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  localparam logic [3:0]         OP_HALT = 4'b1111;
  localparam logic [INSTR_W-1:0] NOP     = 16'h0000;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt_op(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// pc_reg: program counter register.
//   clk, rst  : clock, synchronous active-high reset (loads RESET_PC)
//   load      : load load_pc (highest priority after reset)
//   load_pc   : redirect address
//   inc       : advance by PC_STEP (modulo 2^PC_W)
//   pc        : current PC
//   pc_plus   : pc + PC_STEP, combinational
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            inc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus
);

  assign pc_plus = pc + PC_W'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= load_pc;
    else if (inc)  pc <= pc_plus;
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with IF/ID pipeline register.
//   clk, rst      : clock, synchronous active-high reset
//   PCWrite       : 0 holds the PC (hazard stall)
//   IFIDWrite     : 0 holds the IF/ID register and fetch counter
//   branchTaken   : redirect fetch to branchTarget and flush IF/ID
//   branchTarget  : redirect address
//   imemData      : instruction word at imemAddr (combinational memory)
//   imemAddr      : current PC
//   ifidInstr     : registered instruction for ID
//   ifidPCPlus    : registered PC+PC_STEP of that instruction
//   ifidValid     : 1 = real instruction, 0 = bubble
//   cpuHalted     : 1 once fetch has stopped on HALT
//   fetchCount    : saturating count of instructions accepted into IF/ID
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     PC_STEP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCWrite,
  input  logic               IFIDWrite,
  input  logic               branchTaken,
  input  logic [PC_W-1:0]    branchTarget,
  input  logic [INSTR_W-1:0] imemData,
  output logic [PC_W-1:0]    imemAddr,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [PC_W-1:0]    ifidPCPlus,
  output logic               ifidValid,
  output logic               cpuHalted,
  output logic [15:0]        fetchCount
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus;
  logic            halt_word;
  logic            running;
  logic            pc_inc;

  assign halt_word = is_halt_op(imemData);
  assign running   = (state == RUN) && !branchTaken;
  // A HALT word never advances the PC: if IF/ID is stalled it must be
  // seen again next cycle, and once accepted fetch stops on it.
  assign pc_inc    = running && PCWrite && !halt_word;
  assign imemAddr  = pc;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (branchTaken),
    .load_pc (branchTarget),
    .inc     (pc_inc),
    .pc      (pc),
    .pc_plus (pc_plus)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cpuHalted  <= 1'b0;
      ifidInstr  <= NOP;
      ifidPCPlus <= '0;
      ifidValid  <= 1'b0;
      fetchCount <= '0;
    end else if (branchTaken) begin
      state     <= RUN;
      cpuHalted <= 1'b0;
      ifidInstr <= NOP;
      ifidValid <= 1'b0;
    end else if (state == HALTED) begin
      if (IFIDWrite) ifidValid <= 1'b0;
    end else if (IFIDWrite) begin
      ifidInstr  <= imemData;
      ifidPCPlus <= pc_plus;
      ifidValid  <= 1'b1;
      if (fetchCount != '1) fetchCount <= fetchCount + 16'd1;
      if (halt_word) begin
        state     <= HALTED;
        cpuHalted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWrite = 1'b0;
  logic        IFIDWrite = 1'b0;
  logic        branchTaken = 1'b0;
  logic [15:0] branchTarget = '0;
  logic [15:0] imemData;
  logic [15:0] imemAddr;
  logic [15:0] ifidInstr;
  logic [15:0] ifidPCPlus;
  logic        ifidValid;
  logic        cpuHalted;
  logic [15:0] fetchCount;

  logic [15:0] halt_addr = 16'h0010;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (16'h0000),
    .PC_STEP  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imemData     (imemData),
    .imemAddr     (imemAddr),
    .ifidInstr    (ifidInstr),
    .ifidPCPlus   (ifidPCPlus),
    .ifidValid    (ifidValid),
    .cpuHalted    (cpuHalted),
    .fetchCount   (fetchCount)
  );

  // Instruction memory: address-derived words (top bit always 0, so never
  // HALT) except a single HALT word at halt_addr.
  function automatic logic [15:0] mem(input logic [15:0] a, input logic [15:0] h);
    if (a == h) return 16'hF000;
    return {1'b0, a[15:1]} ^ 16'h2A5A;
  endfunction

  assign imemData = mem(imemAddr, halt_addr);

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pcplus;
    logic        valid;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural view of the fetch stage.
  logic [15:0] m_pc = '0, m_instr = '0, m_pcplus = '0, m_cnt = '0;
  logic        m_valid = 1'b0, m_halted = 1'b0;

  task automatic cyc(input logic r, input logic pw, input logic iw,
                     input logic br, input logic [15:0] tgt);
    logic [15:0] w;
    exp_t e;
    @(negedge clk);
    rst = r; PCWrite = pw; IFIDWrite = iw; branchTaken = br; branchTarget = tgt;
    w = mem(m_pc, halt_addr);
    if (r) begin
      m_pc = 16'h0000; m_instr = 0; m_pcplus = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
    end else if (br) begin
      m_pc = tgt; m_halted = 0; m_valid = 0; m_instr = 0;
    end else if (m_halted) begin
      if (iw) m_valid = 0;
    end else begin
      if (iw) begin
        m_instr = w; m_pcplus = m_pc + 16'd2; m_valid = 1;
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        if (w[15:12] == 4'hF) m_halted = 1;
      end
      if (pw && w[15:12] != 4'hF) m_pc = m_pc + 16'd2;
    end
    e.addr = m_pc; e.instr = m_instr; e.pcplus = m_pcplus;
    e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every registered update is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imemAddr",   imemAddr,   e.addr);
        chk("ifidInstr",  ifidInstr,  e.instr);
        if (e.valid) chk("ifidPCPlus", ifidPCPlus, e.pcplus);
        chk("ifidValid",  {15'b0, ifidValid}, {15'b0, e.valid});
        chk("cpuHalted",  {15'b0, cpuHalted}, {15'b0, e.halted});
        chk("fetchCount", fetchCount, e.cnt);
      end
    end
  end

  initial begin
    int sel;
    logic pw, iw, br, r;
    logic [15:0] tgt;
    // reset, then free run from RESET_PC
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 16'h1234);
    repeat (4) cyc(0, 1, 1, 0, 0);
    // full stall at PC=8, then resume
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 1, 0, 0);
    // split stalls
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // branch wins over PCWrite=0
    cyc(0, 0, 1, 1, 16'h0040);
    repeat (2) cyc(0, 1, 1, 0, 0);
    // HALT at 0x0010, stay halted, redirect to 0x0020
    cyc(0, 1, 1, 1, 16'h0010);
    repeat (4) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 16'h0020);
    repeat (2) cyc(0, 1, 1, 0, 0);
    // reset while halted with a branch pending
    cyc(0, 1, 1, 1, 16'h0010);
    repeat (3) cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 16'h0030);
    repeat (2) cyc(0, 1, 1, 0, 0);
    // PC wraparound
    cyc(0, 1, 1, 1, 16'hFFFE);
    repeat (3) cyc(0, 1, 1, 0, 0);
    // HALT presented while IF/ID stalled is re-evaluated
    cyc(0, 1, 1, 1, 16'h0010);
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 16'h0000);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) halt_addr = {8'h00, 8'($urandom_range(0, 127)) & 8'hFE};
      sel = $urandom_range(0, 9);
      pw = (sel <= 6) || (sel == 8);
      iw = (sel <= 6) || (sel == 9);
      br = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 199) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 16'($urandom) & 16'hFFFE
                                        : {8'h00, 8'($urandom_range(0, 255)) & 8'hFE};
      cyc(r, pw, iw, br, tgt);
    end
    // drain with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
